// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg: shared definitions for the multiply/divide sequencer (md_ctrl).
//   - MD op encodings as carried on the 3-bit `op` bus
//   - sequencer state encoding
//   - default latencies and busy-counter width
// -----------------------------------------------------------------------------
package md_pkg;

    // Op encodings; 6 and 7 are reserved and behave as no-ops.
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    // Latencies are limited to 1..15, so four bits hold any count.
    localparam int MD_CNT_W = 4;

endpackage

// File: rtl/mux322.sv
// -----------------------------------------------------------------------------
// mux322: 32-bit 2:1 multiplexer.
//   a   : selected when sel == 0
//   b   : selected when sel == 1
//   sel : select
//   y   : output
// -----------------------------------------------------------------------------
module mux322 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sel,
    output logic [31:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/md_ctrl.sv
// -----------------------------------------------------------------------------
// md_ctrl: multiply/divide sequencer in the EX stage of the pipelined MIPS core.
//
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, owns the architectural HI/LO registers
// and models multi-cycle latency with a down-counter. The result of a MULT/DIV
// is computed at the accepting edge into pending registers and copied into
// HI/LO only when the counter expires, so HI/LO never show partial results.
//
// Ports:
//   clk      : clock, all state updates on the rising edge
//   reset    : synchronous, active-low reset
//   start    : EX-stage MD instruction valid this cycle
//   op       : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   a, b     : rs / rt operands (already forwarded)
//   hilo_sel : read select for rdata, 0 LO, 1 HI
//   flush    : (MD_FLUSH_EN only) abandon the in-flight operation
//   busy     : operation in flight
//   hi, lo   : architectural HI / LO
//   rdata    : hilo_sel ? hi : lo, combinational
//
// Configuration macro: MD_FLUSH_EN adds the `flush` input. Without it every
// accepted operation runs to completion.
// -----------------------------------------------------------------------------
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hilo_sel,
`ifdef MD_FLUSH_EN
    input  logic        flush,
`endif
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    md_state_e             state_q, state_d;
    logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic [31:0]           hi_q, hi_d;
    logic [31:0]           lo_q, lo_d;
    logic [31:0]           pend_hi_q, pend_hi_d;
    logic [31:0]           pend_lo_q, pend_lo_d;

    logic                  flush_w;
    logic [63:0]           mul_r;
    logic [63:0]           div_r;

`ifdef MD_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Full 64-bit product, {HI, LO}. Operands are widened first so the low
    // 64 bits of the product are exact for both signednesses.
    function automatic logic [63:0] mul_res(input logic [31:0] x,
                                            input logic [31:0] y,
                                            input logic        is_signed);
        logic signed [63:0] xs, ys, ps;
        logic        [63:0] xu, yu, pu;
        xs = {{32{x[31]}}, x};
        ys = {{32{y[31]}}, y};
        xu = {32'd0, x};
        yu = {32'd0, y};
        ps = xs * ys;
        pu = xu * yu;
        return is_signed ? $unsigned(ps) : pu;
    endfunction

    // Quotient in LO, remainder in HI. A zero divisor leaves HI/LO as they
    // are; the one signed overflow case (INT_MIN / -1) is pinned explicitly.
    function automatic logic [63:0] div_res(input logic [31:0] x,
                                            input logic [31:0] y,
                                            input logic        is_signed,
                                            input logic [31:0] cur_hi,
                                            input logic [31:0] cur_lo);
        logic signed [31:0] xs, ys, qs, rs;
        logic        [63:0] r;
        xs = x;
        ys = y;
        qs = '0;
        rs = '0;
        if (y == 32'd0) begin
            r = {cur_hi, cur_lo};
        end else if (is_signed) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                r = {32'd0, 32'h8000_0000};
            end else begin
                qs = xs / ys;
                rs = xs % ys;
                r  = {rs, qs};
            end
        end else begin
            r = {x % y, x / y};
        end
        return r;
    endfunction

    assign mul_r = mul_res(a, b, op == MD_MULT);
    assign div_r = div_res(a, b, op == MD_DIV, hi_q, lo_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;

        case (state_q)
            MD_IDLE: begin
                if (start && !flush_w) begin
                    case (op)
                        MD_MULT, MD_MULTU: begin
                            {pend_hi_d, pend_lo_d} = mul_r;
                            cnt_d   = MD_CNT_W'(MULT_CYCLES);
                            state_d = MD_RUN;
                            busy_d  = 1'b1;
                        end
                        MD_DIV, MD_DIVU: begin
                            {pend_hi_d, pend_lo_d} = div_r;
                            cnt_d   = MD_CNT_W'(DIV_CYCLES);
                            state_d = MD_RUN;
                            busy_d  = 1'b1;
                        end
                        MD_MTHI: hi_d = a;
                        MD_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            MD_RUN: begin
                // Flush wins over a commit landing on the same edge.
                if (flush_w) begin
                    pend_hi_d = '0;
                    pend_lo_d = '0;
                    cnt_d     = '0;
                    state_d   = MD_IDLE;
                    busy_d    = 1'b0;
                end else if (cnt_q == MD_CNT_W'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    cnt_d   = '0;
                    state_d = MD_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - MD_CNT_W'(1);
                end
            end
            default: begin
                state_d = MD_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    mux322 u_rd_mux (
        .a   (lo_q),
        .b   (hi_q),
        .sel (hilo_sel),
        .y   (rdata)
    );

endmodule

// File: tb/tb_md_ctrl.sv
module tb_md_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        hilo_sel = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] hi, lo, rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cyc;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    vec_t        vecs [16];
    exp_t        sb [$];
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    md_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hilo_sel (hilo_sel),
`ifdef MD_FLUSH_EN
        .flush    (flush),
`endif
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .rdata    (rdata)
    );

    always #5 clk = ~clk;

    // The pipeline must never present an instruction while busy.
    always @(posedge clk) begin
        if (reset && start && busy === 1'b1) begin
            errors++;
            $display("FAIL start_while_busy: start=%b busy=%b, required busy=0", start, busy);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One-cycle start pulse; returns at the negedge after the accepting edge.
    task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue(input vec_t v);
        exp_t e;
        e.hi  = v.exp_hi;
        e.lo  = v.exp_lo;
        e.cyc = v.cyc;
        sb.push_back(e);
        drive(v.op, v.a, v.b);
    endtask

    // Count busy cycles, require HI/LO to hold their old values meanwhile,
    // then pop the scoreboard and compare the committed result.
    task automatic wait_done(input string name);
        exp_t e;
        int   n;
        logic stale_ok;
        n = 0;
        stale_ok = 1'b1;
        while (busy === 1'b1 && n < 40) begin
            if (hi !== model_hi || lo !== model_lo) stale_ok = 1'b0;
            n++;
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_sb: got empty scoreboard, expected one entry", name);
            return;
        end
        e = sb.pop_front();
        chk({name, "_cycles"}, 32'(n), 32'(e.cyc));
        if (e.cyc > 0) chk({name, "_hold"}, {31'd0, stale_ok}, 32'd1);
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
        chk({name, "_hi"}, hi, e.hi);
        chk({name, "_lo"}, lo, e.lo);
        hilo_sel = 1'b0;
        #1;
        chk({name, "_rdata_lo"}, rdata, e.lo);
        hilo_sel = 1'b1;
        #1;
        chk({name, "_rdata_hi"}, rdata, e.hi);
        model_hi = e.hi;
        model_lo = e.lo;
    endtask

    initial begin
        //            op     a             b             exp_hi        exp_lo        cyc
        vecs[0]  = '{3'd4, 32'h12345678, 32'h0,        32'h12345678, 32'h00000000, 0};
        vecs[1]  = '{3'd0, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[2]  = '{3'd1, 32'hFFFFFFFE, 32'h3,        32'h00000002, 32'hFFFFFFFA, 5};
        vecs[3]  = '{3'd2, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[4]  = '{3'd4, 32'h000000AA, 32'h0,        32'h000000AA, 32'hFFFFFFFD, 0};
        vecs[5]  = '{3'd5, 32'h000000BB, 32'h0,        32'h000000AA, 32'h000000BB, 0};
        vecs[6]  = '{3'd2, 32'h00000005, 32'h0,        32'h000000AA, 32'h000000BB, 10};
        vecs[7]  = '{3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
        vecs[8]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[9]  = '{3'd3, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 10};
        vecs[10] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[11] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};
        vecs[12] = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[13] = '{3'd6, 32'h0000DEAD, 32'h1,        32'h00000001, 32'hFFFFFFFD, 0};
        vecs[14] = '{3'd3, 32'h00000005, 32'h0,        32'h00000001, 32'hFFFFFFFD, 10};
        vecs[15] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};

        // Reset
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        hilo_sel = 1'b0;
        #1;
        chk("rst_rdata", rdata, 32'd0);

        // Table-driven operations
        for (int i = 0; i < 16; i++) begin
            issue(vecs[i]);
            wait_done($sformatf("vec%0d", i));
        end

        // Reset asserted on the third busy cycle of a MULT discards the result
        drive(3'd0, 32'hFFFFFFFE, 32'h3);
        repeat (2) @(negedge clk);
        chk("midrst_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        begin
            logic quiet;
            quiet = 1'b1;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) quiet = 1'b0;
            end
            chk("midrst_no_commit", {31'd0, quiet}, 32'd1);
        end
        model_hi = 32'd0;
        model_lo = 32'd0;

`ifdef MD_FLUSH_EN
        // Flush on the fourth busy cycle of DIVU 100/7 leaves HI/LO untouched
        issue('{3'd4, 32'h11, 32'h0, 32'h11, 32'h0, 0});
        wait_done("fl_mthi");
        issue('{3'd5, 32'h22, 32'h0, 32'h11, 32'h22, 0});
        wait_done("fl_mtlo");
        drive(3'd3, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        chk("fl_busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_busy", {31'd0, busy}, 32'd0);
        chk("fl_hi", hi, 32'h11);
        chk("fl_lo", lo, 32'h22);
        begin
            logic quiet;
            quiet = 1'b1;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) quiet = 1'b0;
            end
            chk("fl_no_commit", {31'd0, quiet}, 32'd1);
        end
        // flush together with start in IDLE: start is ignored
        @(negedge clk);
        flush = 1'b1;
        start = 1'b1;
        op    = 3'd4;
        a     = 32'h99;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        chk("fl_idle_hi", hi, 32'h11);
        chk("fl_idle_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        flush = 1'b1;
        start = 1'b1;
        op    = 3'd2;
        a     = 32'd9;
        b     = 32'd2;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        chk("fl_idle_div_busy", {31'd0, busy}, 32'd0);
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
